np_iomem_ctrl: RTL and testbench

Bus controller between the picosoc `iomem` port and the on-chip peripherals (GPIO, and future timer/PWM/SPI slots). It decodes each CPU `iomem` transaction by address page, sequences a single outstanding access to exactly one peripheral slot, and returns the read data and ready to the CPU. Unmapped pages and non-responding peripherals are terminated with an error word so the CPU never hangs; error events are counted for debug. It replaces per-peripheral ad-hoc ready logic in `np_top`.

---
 rtl/np_iomem_ctrl_pkg.sv | 29 ++
 rtl/np_iomem_ctrl_if.sv | 28 ++
 rtl/np_iomem_ctrl_timeout.sv | 27 ++
 rtl/np_iomem_ctrl.sv | 123 ++++++++++++
 tb/tb_np_iomem_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/np_iomem_ctrl_pkg.sv
// Shared types and constants for the iomem bus controller: error word,
// peripheral page map, FSM state encoding and the latched request.
package np_iomem_ctrl_pkg;

  localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
  localparam logic [7:0]  PAGE_GPIO  = 8'h03;
  localparam logic [7:0]  PAGE_TIMER = 8'h04;
  localparam logic [7:0]  PAGE_PWM   = 8'h05;
  localparam logic [7:0]  PAGE_SPI   = 8'h06;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } iomem_req_t;

  // Slot offset of an address; wraps so pages below the base land high.
  function automatic logic [7:0] page_offset(input logic [31:0] addr,
                                             input logic [7:0]  base);
    return addr[31:24] - base;
  endfunction

endpackage

// File: rtl/np_iomem_ctrl_if.sv
// CPU iomem port plus the shared peripheral-slot bus; slot i read data
// sits at bits [32i+31:32i] of s_rdata.
interface np_iomem_ctrl_if #(
  parameter int NUM_SLAVES = 4
);
  logic                         iomem_valid;
  logic                         iomem_ready;
  logic [3:0]                   iomem_wstrb;
  logic [31:0]                  iomem_addr;
  logic [31:0]                  iomem_wdata;
  logic [31:0]                  iomem_rdata;
  logic [NUM_SLAVES-1:0]        s_valid;
  logic [NUM_SLAVES-1:0]        s_ready;
  logic [3:0]                   s_wstrb;
  logic [31:0]                  s_addr;
  logic [31:0]                  s_wdata;
  logic [NUM_SLAVES-1:0][31:0]  s_rdata;

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, s_ready, s_rdata,
    output iomem_ready, iomem_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, s_ready, s_rdata,
    input  iomem_ready, iomem_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );
endinterface

// File: rtl/np_iomem_ctrl_timeout.sv
// 8-bit access watchdog: expired_o is high while the count sits at LIMIT-1.
module np_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/np_iomem_ctrl.sv
// iomem bus controller: page decode, one outstanding slot access, error
// termination for unmapped pages and silent slots, error bookkeeping.
module np_iomem_ctrl
  import np_iomem_ctrl_pkg::*;
#(
  parameter int         NUM_SLAVES = 4,
  parameter logic [7:0] BASE_PAGE  = PAGE_GPIO,
  parameter int         TIMEOUT    = 255
) (
  input  logic           core_clock,
  input  logic           reset_core,
  np_iomem_ctrl_if.slave bus,
  output logic [7:0]     err_count,
  output logic [31:0]    last_err_addr
);
  localparam int         IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [7:0] NSLV = 8'(NUM_SLAVES);

  state_e                state_q, state_d;
  iomem_req_t            req_q, req_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [NUM_SLAVES-1:0] sv_q, sv_d;
  logic                  rdy_q, rdy_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [7:0]            errc_q, errc_d;
  logic [31:0]           erra_q, erra_d;
  logic [7:0]            page;
  logic                  tmo_clr, tmo_en, tmo_exp, err;

  assign page = page_offset(bus.iomem_addr, BASE_PAGE);

  np_timeout_counter #(.LIMIT(TIMEOUT)) u_tmo (
    .clk_i     (core_clock),
    .rst_i     (reset_core),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    idx_d   = idx_q;
    sv_d    = '0;
    rdy_d   = 1'b0;
    rdata_d = rdata_q;
    err     = 1'b0;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.iomem_valid) begin
        req_d = '{addr: bus.iomem_addr, wdata: bus.iomem_wdata, wstrb: bus.iomem_wstrb};
        if (page < NSLV) begin
          idx_d   = page[IDXW-1:0];
          tmo_clr = 1'b1;
          for (int i = 0; i < NUM_SLAVES; i++) sv_d[i] = (page == 8'(i));
          state_d = ST_ACCESS;
        end else begin
          rdata_d = ERR_DATA;
          err     = 1'b1;
          rdy_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_ACCESS: begin
        tmo_en = 1'b1;
        // Ready beats a simultaneous timeout: real data, no error.
        if (bus.s_ready[idx_q]) begin
          rdata_d = bus.s_rdata[idx_q];
          rdy_d   = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_exp) begin
          rdata_d = ERR_DATA;
          err     = 1'b1;
          rdy_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          sv_d = sv_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    errc_d = errc_q;
    erra_d = erra_q;
    if (err) begin
      if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
      erra_d = req_d.addr;
    end
  end

  always_ff @(posedge core_clock) begin
    if (reset_core) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      idx_q   <= '0;
      sv_q    <= '0;
      rdy_q   <= 1'b0;
      rdata_q <= '0;
      errc_q  <= '0;
      erra_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      sv_q    <= sv_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      errc_q  <= errc_d;
      erra_q  <= erra_d;
    end
  end

  assign bus.s_valid     = sv_q;
  assign bus.s_addr      = req_q.addr;
  assign bus.s_wdata     = req_q.wdata;
  assign bus.s_wstrb     = req_q.wstrb;
  assign bus.iomem_ready = rdy_q;
  assign bus.iomem_rdata = rdata_q;
  assign err_count       = errc_q;
  assign last_err_addr   = erra_q;
endmodule

// File: tb/tb_np_iomem_ctrl.sv
// Directed bench for np_iomem_ctrl: mapped reads/writes, unmapped pages,
// timeouts, foreign-slot ready, mid-access reset and error-count saturation.
module tb_np_iomem_ctrl;
  localparam int NS = 4;

  logic        core_clock = 1'b0;
  logic        reset_core = 1'b1;
  logic [7:0]  err_count;
  logic [31:0] last_err_addr;
  int          n_tests = 0;
  int          n_fail  = 0;

  np_iomem_ctrl_if #(.NUM_SLAVES(NS)) bus ();

  np_iomem_ctrl #(.NUM_SLAVES(NS), .BASE_PAGE(8'h03), .TIMEOUT(255)) dut (
    .core_clock    (core_clock),
    .reset_core    (reset_core),
    .bus           (bus),
    .err_count     (err_count),
    .last_err_addr (last_err_addr)
  );

  always #5 core_clock = ~core_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clock);
    #1;
  endtask

  // Issues one CPU request in the current cycle (cycle 0) and plays slot
  // `slot` answering on its lat-th s_valid cycle (lat=0: never answers).
  // `noise` ready bits are raised on other slots during every access cycle.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input int slot, input int lat,
                      input logic [31:0] sdata, input logic [NS-1:0] noise,
                      output int nval, output int rdy_c, output logic [31:0] rdata,
                      output bit stable, output bit single);
    logic [NS-1:0] oh;
    oh     = '0;
    oh[slot] = 1'b1;
    nval   = 0;
    rdy_c  = 0;
    rdata  = 'x;
    stable = 1'b1;
    for (int i = 0; i < NS; i++) bus.s_rdata[i] = 32'hBAD0_0000 | 32'(i);
    bus.s_rdata[slot] = sdata;
    bus.s_ready       = '0;
    bus.iomem_addr    = addr;
    bus.iomem_wdata   = wdata;
    bus.iomem_wstrb   = wstrb;
    bus.iomem_valid   = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (bus.iomem_ready) begin
        rdy_c = c;
        rdata = bus.iomem_rdata;
        break;
      end
      if (bus.s_valid != '0) begin
        nval++;
        if (bus.s_valid != oh || bus.s_addr != addr || bus.s_wdata != wdata ||
            bus.s_wstrb != wstrb) stable = 1'b0;
        bus.s_ready = noise | ((lat != 0 && nval == lat) ? oh : '0);
      end else begin
        bus.s_ready = '0;
      end
    end
    bus.iomem_valid = 1'b0;
    bus.s_ready     = '0;
    step();
    single = !bus.iomem_ready;
  endtask

  int          nv, rc;
  logic [31:0] rd;
  bit          st, sg;

  initial begin
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = '0;
    bus.iomem_wdata = '0;
    bus.iomem_wstrb = '0;
    bus.s_ready     = '0;
    bus.s_rdata     = '0;
    step();
    step();
    reset_core = 1'b0;
    chk("rst_ready", 32'(bus.iomem_ready), 32'd0);
    chk("rst_svalid", 32'(bus.s_valid), 32'd0);
    chk("rst_rdata", bus.iomem_rdata, 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    step();

    // Registered slave on slot 0: s_valid cycles 1-2, ready at cycle 3.
    xfer(32'h0300_0000, 32'h0, 4'h0, 0, 2, 32'h0000_00A5, '0, nv, rc, rd, st, sg);
    chk("rd0_nval", 32'(nv), 32'd2);
    chk("rd0_rdyc", 32'(rc), 32'd3);
    chk("rd0_rdata", rd, 32'h0000_00A5);
    chk("rd0_onehot", 32'(st), 32'd1);
    chk("rd0_single", 32'(sg), 32'd1);

    xfer(32'h0500_0004, 32'h1234_5678, 4'b0011, 2, 3, 32'h0000_0077, '0, nv, rc, rd, st, sg);
    chk("wr2_nval", 32'(nv), 32'd3);
    chk("wr2_rdyc", 32'(rc), 32'd4);
    chk("wr2_stable", 32'(st), 32'd1);
    chk("wr2_single", 32'(sg), 32'd1);
    chk("wr2_errcnt", 32'(err_count), 32'd0);

    xfer(32'h0200_0000, 32'h0, 4'h0, 0, 1, 32'h1, '0, nv, rc, rd, st, sg);
    chk("un02_rdyc", 32'(rc), 32'd1);
    chk("un02_nval", 32'(nv), 32'd0);
    chk("un02_rdata", rd, 32'hDEAD_BEEF);
    chk("un02_errcnt", 32'(err_count), 32'd1);
    chk("un02_lastaddr", last_err_addr, 32'h0200_0000);
    xfer(32'h0700_0000, 32'h0, 4'h0, 0, 1, 32'h1, '0, nv, rc, rd, st, sg);
    chk("un07_rdyc", 32'(rc), 32'd1);
    chk("un07_rdata", rd, 32'hDEAD_BEEF);
    chk("un07_errcnt", 32'(err_count), 32'd2);
    chk("un07_lastaddr", last_err_addr, 32'h0700_0000);

    xfer(32'h0400_0010, 32'h0, 4'h0, 1, 0, 32'h0000_1111, '0, nv, rc, rd, st, sg);
    chk("tmo_nval", 32'(nv), 32'd255);
    chk("tmo_rdyc", 32'(rc), 32'd256);
    chk("tmo_rdata", rd, 32'hDEAD_BEEF);
    chk("tmo_errcnt", 32'(err_count), 32'd3);
    chk("tmo_lastaddr", last_err_addr, 32'h0400_0010);

    // Slot 3 raises ready throughout a slot 1 access; only slot 1 counts.
    xfer(32'h0400_0020, 32'h0, 4'h0, 1, 3, 32'h0000_2222, 4'b1000, nv, rc, rd, st, sg);
    chk("foreign_nval", 32'(nv), 32'd3);
    chk("foreign_rdyc", 32'(rc), 32'd4);
    chk("foreign_rdata", rd, 32'h0000_2222);

    xfer(32'h0400_0030, 32'h0, 4'h0, 1, 255, 32'h0000_3333, '0, nv, rc, rd, st, sg);
    chk("edge_nval", 32'(nv), 32'd255);
    chk("edge_rdata", rd, 32'h0000_3333);
    chk("edge_errcnt", 32'(err_count), 32'd3);

    // Reset in the middle of a silent access.
    bus.s_ready     = '0;
    bus.iomem_addr  = 32'h0300_0040;
    bus.iomem_valid = 1'b1;
    step();
    step();
    chk("mid_svalid_pre", 32'(bus.s_valid), 32'd1);
    reset_core      = 1'b1;
    bus.iomem_valid = 1'b0;
    step();
    chk("mid_svalid", 32'(bus.s_valid), 32'd0);
    chk("mid_ready", 32'(bus.iomem_ready), 32'd0);
    chk("mid_errcnt", 32'(err_count), 32'd0);
    chk("mid_saddr", bus.s_addr, 32'd0);
    chk("mid_lastaddr", last_err_addr, 32'd0);
    reset_core = 1'b0;
    step();
    xfer(32'h0300_0044, 32'h0, 4'h0, 0, 1, 32'h0000_0042, '0, nv, rc, rd, st, sg);
    chk("post_rdyc", 32'(rc), 32'd2);
    chk("post_rdata", rd, 32'h0000_0042);

    for (int i = 0; i < 300; i++) begin
      xfer(32'h0900_0000 | 32'(i), 32'h0, 4'h0, 0, 1, 32'h0, '0, nv, rc, rd, st, sg);
      if (i == 253) chk("sat_254", 32'(err_count), 32'h0000_00FE);
    end
    chk("sat_errcnt", 32'(err_count), 32'h0000_00FF);
    chk("sat_lastaddr", last_err_addr, 32'h0900_012B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
